fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the instruction memory. It owns the program counter and drives `iaddr` each cycle. It captures the returned 32-bit `instruction` together with its PC into a 2-entry fetch queue, and presents the queued instructions to decode through a valid/ready handshake. Control flow changes (branch/jump) arrive as a redirect that reloads the PC and flushes the queue.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `QDEPTH`, 2: fetch-queue entries; legal values are 2 and 4.
- `clk`  in  1: single clock, all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `iaddr`  out  32: byte address to instruction memory; equals current PC.
- `instruction`  in  32: instruction memory read data for `iaddr`, valid within the same cycle.
- `redirect_valid`  in  1: load a new PC this cycle.
- `redirect_pc`  in  32: target PC for a redirect.
- `halt_req`  in  1: stop fetching after the current cycle.
- `out_valid`  out  1: queue head is valid.
- `out_ready`  in  1: decode accepts the head.
- `out_instr`  out  32: head instruction.
- `out_pc`  out  32: PC of the head instruction.
- `halted`  out  1: fetch FSM is in HALT.
- `fetch_fault`  out  1: misaligned redirect detected; sticky until reset.

## Operation
- FSM states and transitions:
  - RUN: normal fetching.
  - HALT: reached from RUN on `halt_req` (and no redirect).
  - HALT → RUN only on `redirect_valid`.
  - Reset enters RUN.
- Fetch in RUN:
  - A fetch occurs when the queue is not full, or when it is full and a pop happens in the same cycle.
  - On fetch, enqueue {`pc`, `instruction`} and set `pc <= pc + 4`.
- Pop: `out_valid && out_ready` removes the head.
- Redirect has highest priority:
  - Sets `pc <= redirect_pc` and empties the queue.
  - Suppresses that cycle's enqueue and pop.
  - Forces the FSM to RUN, even if `halt_req` is also asserted.
- `halt_req` with no redirect:
  - A fetch in that same cycle still completes.
  - The FSM then enters HALT; no further enqueues occur.
  - The queue continues to drain.
- PC arithmetic:
  - 32-bit, wraps modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
  - No range check against memory size.
- `iaddr` is combinational from the `pc` register; it never depends on `redirect_valid` in the same cycle.

## Timing
- Reset values:
  - `pc` = `RESET_PC`; queue empty.
  - `out_valid` = 0, `halted` = 0, `fetch_fault` = 0.
  - `out_instr` and `out_pc` are don't-care while `out_valid` = 0; reset them to 0.
- Latency: the instruction at `iaddr` in cycle N appears at the queue head with `out_valid` = 1 in cycle N+1 at the earliest.
- Sustained throughput: 1 instruction per cycle while `out_ready` = 1.
- Redirect in cycle N:
  - `out_valid` = 0 in N+1.
  - `iaddr` = `redirect_pc` in N+1.
  - The first instruction from the target is valid at N+2.
- Queue full and no pop: `pc` holds, `iaddr` is stable, no enqueue.
- Simultaneous pop and enqueue when full: both occur; the count is unchanged.
- `rst_n` low mid-operation: next edge applies all reset values and discards the queue contents.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_fault`, enters HALT, and does not load the PC.
- Not defined:
  - `fetch_fault` is tied 0.
  - `redirect_pc[1:0]` is forced to 0 when loaded.

## Structure
- Shared package `fetch_pkg`:
  - `RESET_PC` default.
  - Instruction width constant 32.
  - PC increment constant 4.
  - FSM state enum (RUN, HALT).
  - Queue-entry struct {pc, instr}.
- Sub-module `fetch_queue`: synchronous FIFO of depth `QDEPTH` with push, pop, flush, full, empty.
- The PC, FSM and redirect logic live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0 and memory words 0x00000013, 0x00100093, `out_ready`=1 → cycle 1: `out_pc`=0, `out_instr`=0x00000013; cycle 2: `out_pc`=4, `out_instr`=0x00100093.
- Hold `out_ready`=0 for 5 cycles → queue fills with PCs 0 and 4, `iaddr` holds 8; releasing `out_ready` drains 0, 4, 8 in consecutive cycles.
- Redirect to 0x20 while the queue holds 2 entries → next cycle `out_valid`=0 and `iaddr`=0x20; the cycle after, `out_pc`=0x20.
- Redirect asserted together with `halt_req` and a pop → redirect wins: queue flushed, `halted`=0.
- `halt_req` at PC 0x10 → `halted`=1, `iaddr` stays 0x14, queue drains to empty; a redirect to 0 resumes RUN.
- Redirect to 0x22:
  - With `FETCH_ALIGN_CHECK_EN`: `fetch_fault`=1, `halted`=1, PC unchanged.
  - Without it: `iaddr`=0x20.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fetch_pkg;

    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] PC_INC       = 32'd4;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } qentry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: full_o blocks pushes unless a pop happens in the same cycle.
//
// Ports: clk/rst_n (sync active-low); push_i/push_dat_i write the tail;
// pop_i removes the head; flush_i empties the queue (wins over push/pop);
// head_dat_o is the head entry; full_o/empty_o report occupancy.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  qentry_t push_dat_i,
    input  logic    pop_i,
    input  logic    flush_i,
    output qentry_t head_dat_o,
    output logic    full_o,
    output logic    empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    qentry_t         mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;

    assign head_dat_o = mem_q[rd_ptr_q];
    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            // Entries are cleared so the head reads as zero after reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, captures memory data into a small queue.
// Latency: instruction at iaddr in cycle N is at the head in N+1.
// Backpressure: full queue with no pop holds the PC; decode stalls via out_ready.
//
// Ports: clk/rst_n (sync active-low); iaddr/instruction to imem;
// redirect_valid/redirect_pc reload PC and flush; halt_req stops fetching;
// out_valid/out_ready/out_instr/out_pc decode handshake; halted, fetch_fault status.
// Optional macro FETCH_ALIGN_CHECK_EN: misaligned redirect faults and halts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          QDEPTH   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        iaddr,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               halt_req,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [31:0]        out_pc,
    output logic               halted,
    output logic               fetch_fault
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;

    logic    q_full, q_empty;
    logic    q_push, q_pop, q_flush;
    qentry_t q_push_dat, q_head;

    // Redirect suppresses both ends of the queue in its cycle.
    assign q_pop   = !q_empty && out_ready && !redirect_valid;
    assign q_push  = (state_q == ST_RUN) && (!q_full || q_pop) && !redirect_valid;
    assign q_flush = redirect_valid;

    assign q_push_dat.pc    = pc_q;
    assign q_push_dat.instr = instruction;

    assign iaddr     = pc_q;
    assign out_valid = !q_empty;
    assign out_instr = q_head.instr;
    assign out_pc    = q_head.pc;
    assign halted    = (state_q == ST_HALT);

`ifdef FETCH_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    assign fetch_fault = fault_q;
`else
    // Low address bits are dropped on redirect in this build.
    logic unused_align;
    assign unused_align = ^redirect_pc[1:0];
    assign fetch_fault  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d = fault_q;
`endif
        if (redirect_valid) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                // Bad target: keep the old PC and park in HALT until a good redirect.
                fault_d = 1'b1;
                state_d = ST_HALT;
            end else begin
                pc_d    = redirect_pc;
                state_d = ST_RUN;
            end
`else
            pc_d    = {redirect_pc[31:2], 2'b00};
            state_d = ST_RUN;
`endif
        end else begin
            if (q_push) begin
                pc_d = pc_q + PC_INC;
            end
            // The fetch in the halt_req cycle still completes above.
            if (state_q == ST_RUN && halt_req) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q <= fault_d;
`endif
        end
    end

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (q_push),
        .push_dat_i (q_push_dat),
        .pop_i      (q_pop),
        .flush_i    (q_flush),
        .head_dat_o (q_head),
        .full_o     (q_full),
        .empty_o    (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
// Latency: checks are taken on the falling edge, half a cycle after each update.
// Backpressure: exercised by holding out_ready low until the queue fills.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] iaddr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fetch_fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Memory image: two real words at 0 and 4, a recognisable pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)      return 32'h0000_0013;
        else if (a == 32'h4) return 32'h0010_0093;
        else                 return 32'hC0DE_0000 | {16'h0, a[15:0]};
    endfunction

    assign instruction = mem_word(iaddr);

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iaddr          (iaddr),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        out_ready      = 1'b1;
        @(negedge clk);
        step();

        // Reset state
        chk("rst_iaddr",  iaddr,       32'h0);
        chk("rst_valid",  out_valid,   32'h0);
        chk("rst_halted", halted,      32'h0);
        chk("rst_fault",  fetch_fault, 32'h0);
        chk("rst_pc",     out_pc,      32'h0);
        chk("rst_instr",  out_instr,   32'h0);

        // Streaming fetch with out_ready high
        rst_n = 1'b1;
        step();
        chk("c1_valid", out_valid, 32'h1);
        chk("c1_pc",    out_pc,    32'h0);
        chk("c1_instr", out_instr, 32'h0000_0013);
        chk("c1_iaddr", iaddr,     32'h4);
        step();
        chk("c2_valid", out_valid, 32'h1);
        chk("c2_pc",    out_pc,    32'h4);
        chk("c2_instr", out_instr, 32'h0010_0093);
        chk("c2_iaddr", iaddr,     32'h8);

        // Mid-operation reset discards the queue
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        chk("mrst_valid", out_valid, 32'h0);
        chk("mrst_iaddr", iaddr,     32'h0);

        // Backpressure: queue fills with 0 and 4, PC holds at 8
        rst_n = 1'b1;
        step();
        step();
        chk("fill_iaddr2", iaddr, 32'h8);
        step();
        step();
        step();
        chk("hold_iaddr", iaddr,     32'h8);
        chk("hold_valid", out_valid, 32'h1);
        chk("drain0_pc",  out_pc,    32'h0);
        out_ready = 1'b1;
        step();
        chk("drain1_pc",    out_pc, 32'h4);
        chk("drain1_iaddr", iaddr,  32'hC);
        step();
        chk("drain2_pc",    out_pc,    32'h8);
        chk("drain2_instr", out_instr, 32'hC0DE_0008);

        // Queue full ([8,12]); stall and confirm PC stays put
        out_ready = 1'b0;
        step();
        chk("full_iaddr", iaddr,  32'h10);
        chk("full_pc",    out_pc, 32'h8);

        // Redirect while the queue holds two entries
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        chk("redir_valid", out_valid, 32'h0);
        chk("redir_iaddr", iaddr,     32'h20);
        step();
        chk("redir_tgt_valid", out_valid, 32'h1);
        chk("redir_tgt_pc",    out_pc,    32'h20);
        chk("redir_tgt_instr", out_instr, 32'hC0DE_0020);

        // Redirect + halt_req + pop in one cycle: redirect wins
        out_ready      = 1'b1;
        halt_req       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        step();
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        chk("rh_valid",  out_valid, 32'h0);
        chk("rh_halted", halted,    32'h0);
        chk("rh_iaddr",  iaddr,     32'h40);
        step();
        chk("rh_next_pc",    out_pc, 32'h40);
        chk("rh_next_iaddr", iaddr,  32'h44);

        // Halt at PC 0x10: that fetch completes, then fetching stops and queue drains
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        step();
        redirect_valid = 1'b0;
        chk("h_pre_iaddr", iaddr, 32'h10);
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        chk("h_halted", halted,    32'h1);
        chk("h_iaddr",  iaddr,     32'h14);
        chk("h_pc",     out_pc,    32'h10);
        chk("h_instr",  out_instr, 32'hC0DE_0010);
        step();
        chk("h_drained",    out_valid, 32'h0);
        chk("h_iaddr_hold", iaddr,     32'h14);
        step();
        chk("h_still_empty",  out_valid, 32'h0);
        chk("h_still_halted", halted,    32'h1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step();
        redirect_valid = 1'b0;
        chk("resume_halted", halted, 32'h0);
        chk("resume_iaddr",  iaddr,  32'h0);
        step();
        chk("resume_valid", out_valid, 32'h1);
        chk("resume_pc",    out_pc,    32'h0);

        // Misaligned redirect to 0x22 (PC is 4 here)
        redirect_valid = 1'b1;
        redirect_pc    = 32'h22;
        step();
        redirect_valid = 1'b0;
        chk("mis_valid", out_valid, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("mis_fault",  fetch_fault, 32'h1);
        chk("mis_halted", halted,      32'h1);
        chk("mis_iaddr",  iaddr,       32'h4);
        step();
        chk("mis_stay_valid", out_valid, 32'h0);
        chk("mis_stay_iaddr", iaddr,     32'h4);
`else
        chk("mis_fault",  fetch_fault, 32'h0);
        chk("mis_halted", halted,      32'h0);
        chk("mis_iaddr",  iaddr,       32'h20);
        step();
        chk("mis_next_pc",    out_pc,    32'h20);
        chk("mis_next_instr", out_instr, 32'hC0DE_0020);
`endif

        // Reset clears status
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("end_fault",  fetch_fault, 32'h0);
        chk("end_halted", halted,      32'h0);
        chk("end_iaddr",  iaddr,       32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
